// File: rtl/lif_neuron_ec.sv
// Leaky integrate-and-fire neuron array for one conv output channel.
// Taps accumulate weights into a membrane RAM through a 3-stage pipeline
// (S0 address, S1 read, S2 saturating write) that forwards S2 into S1.
// A separate 2-stage activation sweep leaks, thresholds and emits spikes.
// Membrane RAM is zeroed by a one-neuron-per-cycle sweep after reset.
//
// Handshake: the block has no backpressure. A tap is taken on any cycle with
// en_accum=1, neur_addr_invalid=0, en_activ=0 and the clear sweep finished.
// spk_out_valid is a single-cycle strobe qualifying spk_out and spk_out_addr;
// there is no ready, so the consumer must take each result on that cycle.
module lif_neuron_ec #(
  parameter int FRAME_WIDTH    = 28,
  parameter int KERNEL_SIZE    = 3,
  parameter int INPUT_CHANNELS = 2,
  parameter int W_BITS         = 8,
  parameter int MEM_BITS       = 16,
  parameter int THRESH         = 64,
  parameter int BETA_SHIFT     = 3
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   en_accum,
  input  logic                                                   neur_addr_invalid,
  input  logic [$clog2(FRAME_WIDTH)-1:0]                         addr_y,
  input  logic [$clog2(FRAME_WIDTH)-1:0]                         addr_x,
  input  logic [$clog2(KERNEL_SIZE)+1:0]                         filter_phase,
  input  logic [$clog2(INPUT_CHANNELS)+1:0]                      ic,
  input  logic                                                   en_activ,
  input  logic                                                   last_time_step,
  input  logic                                                   w_wr_en,
  input  logic [$clog2(INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE)-1:0] w_wr_addr,
  input  logic [W_BITS-1:0]                                      w_wr_data,
  output logic                                                   spk_out_valid,
  output logic [$clog2(FRAME_WIDTH*FRAME_WIDTH)-1:0]             spk_out_addr,
  output logic                                                   spk_out,
  output logic                                                   overlap_err
);

  localparam int NEUR = FRAME_WIDTH * FRAME_WIDTH;
  localparam int NW   = $clog2(NEUR);
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WD   = INPUT_CHANNELS * KK;
  localparam int WAW  = $clog2(WD);
  localparam int SW   = MEM_BITS + 1;
  localparam logic signed [MEM_BITS-1:0] THR = MEM_BITS'(THRESH);

  logic signed [MEM_BITS-1:0] mem [NEUR];
  logic signed [W_BITS-1:0]   wt  [WD];

  // clear sweep state
  logic          clearing;
  logic [NW-1:0] clr_idx;

  // accumulate pipeline state
  logic                       s1_valid, s2_valid;
  logic [NW-1:0]              s1_n, s2_n;
  logic [WAW-1:0]             s1_wa;
  logic signed [MEM_BITS-1:0] s2_mem;
  logic signed [W_BITS-1:0]   s2_wt;

  // activation state
  logic [NW-1:0] act_idx, a_idx;
  logic          a_valid, a_last;

  logic                       accept, act_go, fwd;
  logic [NW-1:0]              n_calc;
  logic [WAW-1:0]             wa_calc;
  logic signed [SW-1:0]       s2_sum;
  logic signed [MEM_BITS-1:0] acc_res;
  logic signed [MEM_BITS-1:0] act_v, act_leak, act_new;
  logic                       act_fire;

  function automatic logic signed [MEM_BITS-1:0] sat(input logic signed [SW-1:0] s);
    if (s[SW-1] != s[SW-2])
      return s[SW-1] ? {1'b1, {(MEM_BITS-1){1'b0}}} : {1'b0, {(MEM_BITS-1){1'b1}}};
    return s[MEM_BITS-1:0];
  endfunction

  // Activation has priority over a tap; both are ignored while clearing.
  assign accept  = en_accum & ~neur_addr_invalid & ~en_activ & ~clearing;
  assign act_go  = en_activ & ~clearing;
  assign n_calc  = NW'(addr_y) * NW'(FRAME_WIDTH) + NW'(addr_x);
  assign wa_calc = WAW'(ic) * WAW'(KK) + WAW'(filter_phase);
  assign s2_sum  = SW'(s2_mem) + SW'(s2_wt);
  assign acc_res = sat(s2_sum);
  // S1 reads a neuron that S2 is about to overwrite: take the S2 result.
  assign fwd     = s2_valid && (s2_n == s1_n);

  // Activation compute: leak, threshold, subtract-reset or end-of-step clear.
  always_comb begin
    act_v    = (s2_valid && (s2_n == a_idx)) ? acc_res : mem[a_idx];
    act_leak = act_v - (act_v >>> BETA_SHIFT);
    act_fire = (act_leak >= THR);
    act_new  = act_leak;
    if (a_last)        act_new = '0;
    else if (act_fire) act_new = act_leak - THR;
  end

  // Weight RAM: written only through the write port, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && (int'(w_wr_addr) < WD)) wt[w_wr_addr] <= w_wr_data;
  end

  // Membrane RAM writes: clear sweep, accumulate S2, activation write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[clr_idx] <= '0;
      end else begin
        if (s2_valid) mem[s2_n] <= acc_res;
        if (a_valid)  mem[a_idx] <= act_new;
      end
    end
  end

  // Control, pipeline registers and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      clearing      <= 1'b1;
      clr_idx       <= '0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      a_valid       <= 1'b0;
      a_last        <= 1'b0;
      a_idx         <= '0;
      act_idx       <= '0;
      spk_out_valid <= 1'b0;
      spk_out       <= 1'b0;
      spk_out_addr  <= '0;
      overlap_err   <= 1'b0;
    end else begin
      if (clearing) begin
        clr_idx <= clr_idx + NW'(1);
        if (clr_idx == NW'(NEUR - 1)) clearing <= 1'b0;
      end

      s1_valid <= accept;
      if (accept) begin
        s1_n  <= n_calc;
        s1_wa <= wa_calc;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_n   <= s1_n;
        s2_mem <= fwd ? acc_res : mem[s1_n];
        s2_wt  <= (int'(s1_wa) < WD) ? wt[s1_wa] : '0;
      end

      a_valid <= act_go;
      a_idx   <= act_idx;
      a_last  <= last_time_step;
      if (act_go) act_idx <= (act_idx == NW'(NEUR - 1)) ? '0 : act_idx + NW'(1);
      else        act_idx <= '0;

      spk_out_valid <= a_valid;
      if (a_valid) begin
        spk_out      <= act_fire;
        spk_out_addr <= a_idx;
      end

      if (en_accum && en_activ && !clearing) overlap_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_neuron_ec.sv
// Bench for lif_neuron_ec: membrane array model at integer level, spike
// results scoreboarded by address, value and arrival cycle.
module tb_lif_neuron_ec;

  localparam int FW = 28, K = 3, IC = 2, WB = 8, MB = 16, TH = 64, BS = 3;
  localparam int N   = FW * FW;
  localparam int WD  = IC * K * K;
  localparam int AW  = $clog2(FW);
  localparam int FPW = $clog2(K) + 2;
  localparam int ICW = $clog2(IC) + 2;
  localparam int WAW = $clog2(WD);
  localparam int NW  = $clog2(N);
  localparam int MAXV = 2 ** (MB - 1) - 1;
  localparam int MINV = -(2 ** (MB - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_accum = 1'b0, neur_addr_invalid = 1'b0, en_activ = 1'b0, last_time_step = 1'b0;
  logic [AW-1:0]  addr_y = '0, addr_x = '0;
  logic [FPW-1:0] filter_phase = '0;
  logic [ICW-1:0] ic = '0;
  logic           w_wr_en = 1'b0;
  logic [WAW-1:0] w_wr_addr = '0;
  logic [WB-1:0]  w_wr_data = '0;
  logic           spk_out_valid, spk_out, overlap_err;
  logic [NW-1:0]  spk_out_addr;

  lif_neuron_ec #(
    .FRAME_WIDTH(FW), .KERNEL_SIZE(K), .INPUT_CHANNELS(IC), .W_BITS(WB),
    .MEM_BITS(MB), .THRESH(TH), .BETA_SHIFT(BS)
  ) dut (
    .clk(clk), .rst(rst), .en_accum(en_accum), .neur_addr_invalid(neur_addr_invalid),
    .addr_y(addr_y), .addr_x(addr_x), .filter_phase(filter_phase), .ic(ic),
    .en_activ(en_activ), .last_time_step(last_time_step), .w_wr_en(w_wr_en),
    .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .spk_out_valid(spk_out_valid),
    .spk_out_addr(spk_out_addr), .spk_out(spk_out), .overlap_err(overlap_err)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: membrane values, weights, sweep position, sticky error
  int m [N];
  int wm [WD];
  int act_i = 0;
  bit ovl_model = 1'b0;

  // scoreboard
  logic [NW:0] exp_q[$];
  int          exp_cyc_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int sat16(input int s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (spk_out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spike_unexpected: addr %0d spk %0b at cycle %0d, none expected",
                 spk_out_addr, spk_out, cyc);
      end else begin
        logic [NW:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({spk_out_addr, spk_out} !== e || cyc != ec) begin
          errors++;
          $display("FAIL spike: addr %0d spk %0b cycle %0d, expected addr %0d spk %0b cycle %0d",
                   spk_out_addr, spk_out, cyc, e[NW:1], e[0], ec);
        end
      end
    end
  end

  // one driven cycle; the model takes the same cycle's effects at issue time
  task automatic step(input bit acc, input bit inv, input int y, input int x, input int icv,
                      input int fp, input bit act, input bit last, input bit wr, input int wa,
                      input int wd, input bit ignored);
    en_accum = acc; neur_addr_invalid = inv; addr_y = AW'(y); addr_x = AW'(x);
    ic = ICW'(icv); filter_phase = FPW'(fp); en_activ = act; last_time_step = last;
    w_wr_en = wr; w_wr_addr = WAW'(wa); w_wr_data = WB'(wd);
    if (wr) wm[wa] = wd;
    if (!ignored) begin
      if (act) begin
        int v, vp;
        bit spk;
        v   = m[act_i];
        vp  = v - (v >>> BS);
        spk = (vp >= TH);
        m[act_i] = last ? 0 : (spk ? vp - TH : vp);
        exp_q.push_back({NW'(act_i), spk});
        exp_cyc_q.push_back(cyc + 2);
        act_i = (act_i == N - 1) ? 0 : act_i + 1;
        if (acc) ovl_model = 1'b1;
      end else begin
        act_i = 0;
        if (acc && !inv) m[y * FW + x] = sat16(m[y * FW + x] + wm[icv * K * K + fp]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tap(input int y, input int x, input int icv, input int fp);
    step(1, 0, y, x, icv, fp, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wwr(input int a, input int d);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a, d, 0);
  endtask

  task automatic activ(input int n, input bit last);
    repeat (n) step(0, 0, 0, 0, 0, 0, 1, last, 0, 0, 0, 0);
  endtask

  // reset with output checks, then inputs that the clear sweep must ignore
  task automatic do_reset();
    rst = 1'b1;
    en_accum = 0; en_activ = 0; w_wr_en = 0; neur_addr_invalid = 0; last_time_step = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_valid", 32'(spk_out_valid), 0);
      chk("rst_spk", 32'(spk_out), 0);
      chk("rst_addr", 32'(spk_out_addr), 0);
      chk("rst_ovl", 32'(overlap_err), 0);
    end
    exp_q.delete();
    exp_cyc_q.delete();
    foreach (m[i]) m[i] = 0;
    act_i = 0;
    ovl_model = 1'b0;
    rst = 1'b0;
    repeat (780)
      step($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 27),
           $urandom_range(0, 1), $urandom_range(0, 8), $urandom_range(0, 1), 0, 0, 0, 0, 1);
    idle(8);
    chk("ovl_after_clear", 32'(overlap_err), 32'(ovl_model));
  endtask

  initial begin
    do_reset();

    // forwarding: preload 58, then three back-to-back taps of 5 reach 73
    wwr(0, 5); wwr(2, 58);
    tap(1, 1, 0, 2); idle(2);
    tap(1, 1, 0, 0); tap(1, 1, 0, 0); tap(1, 1, 0, 0);
    idle(2); activ(30, 0); idle(2); activ(30, 0); idle(3);

    // leak and subtract reset: 80 -> spike, 6 left, then probe with 66 and 67
    do_reset();
    wwr(3, 80); wwr(4, 66); wwr(10, 67);
    tap(0, 0, 0, 3); idle(2); activ(1, 0); idle(2);
    tap(0, 0, 0, 4); idle(2); activ(1, 0); idle(2);
    tap(0, 0, 0, 10); idle(2); activ(1, 0); idle(3);

    // last time step clears regardless of spike; neuron 1 keeps its leak
    do_reset();
    wwr(5, 72); wwr(6, 8); wwr(7, 10); wwr(11, 80);
    tap(0, 0, 0, 5); tap(0, 1, 0, 6); tap(0, 2, 1, 2); idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(2);
    tap(0, 0, 0, 7); tap(0, 2, 0, 7); idle(2); activ(3, 0); idle(3);

    // saturation both ways, plus a weight write racing an S1 read
    wwr(8, 127); wwr(9, -128);
    repeat (300) tap(0, 2, 0, 8);
    repeat (300) tap(0, 3, 1, 0);
    tap(0, 4, 0, 8); wwr(8, -5); idle(2);
    activ(5, 0); idle(3);

    // invalid taps change nothing; a tap colliding with activation is dropped
    repeat (5) step(1, 1, 0, 5, 0, 3, 0, 0, 0, 0, 0, 0);
    idle(2); activ(6, 0); idle(2);
    chk("ovl_before", 32'(overlap_err), 32'(ovl_model));
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    idle(3);
    chk("ovl_set", 32'(overlap_err), 32'(ovl_model));
    activ(3, 0); idle(3);

    // full sweep, restart after a gap, then a sweep that wraps
    activ(N, 0); idle(1); activ(N + 6, 0); idle(3);
    chk("ovl_held", 32'(overlap_err), 32'(ovl_model));

    // randomized traffic on neurons 0..55 with periodic activation bursts
    do_reset();
    for (int a = 0; a < WD; a++) wwr(a, $urandom_range(0, 80) - 40);
    for (int r = 0; r < 12; r++) begin
      repeat (150) begin
        bit wr, acc, inv;
        wr  = ($urandom_range(0, 99) < 15);
        acc = ($urandom_range(0, 99) < 75);
        inv = ($urandom_range(0, 99) < 15);
        step(acc, inv, $urandom_range(0, 1), $urandom_range(0, 27), $urandom_range(0, 1),
             $urandom_range(0, 8), 0, 0, wr, $urandom_range(0, WD - 1),
             $urandom_range(0, 80) - 40, 0);
      end
      idle(2);
      activ($urandom_range(20, 60), ($urandom_range(0, 3) == 0));
      idle(1);
    end
    idle(4);
    chk("ovl_random", 32'(overlap_err), 32'(ovl_model));

    // reset mid-stream aborts in-flight taps and clears the sticky flag
    wwr(1, 100);
    tap(0, 0, 0, 1); tap(0, 0, 0, 1);
    do_reset();
    chk("ovl_cleared", 32'(overlap_err), 0);
    activ(4, 0); idle(4);

    chk("pending_results", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
